lcd_reader: RTL
===============

# lcd_reader

Read-side companion to the LCD write path. It runs HD44780 read cycles (RW=1) on the 8-bit character-LCD bus: busy-flag/address-counter reads (RS=0) and DDRAM/CGRAM data reads (RS=1). An optional poll mode repeats busy-flag reads until the panel reports ready, so the command sequencer can stop using a fixed inter-command delay. It sits beside LCDController; the top level muxes RS/RW/EN and the LCD_DATA tristate on `outOwn`.

## Interface
- `T_SETUP`, 2: clk cycles RS/RW stable before EN rises (≥40 ns at 50 MHz).
- `T_EN_HI`, 16: clk cycles EN held high; data sampled on the last one.
- `T_EN_LO`, 14: clk cycles EN low after fall, for hold and cycle time; total cycle ≥500 ns.
- `POLL_MAX`, 1023: maximum busy-flag reads per poll request.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `inStart` in 1: request; level, held until `outDone` is seen.
- `inRS` in 1: 0 = BF/AC read, 1 = data read; sampled when a request is accepted.
- `inPoll` in 1: with `inRS`=0, repeat reads until BF=0; sampled when a request is accepted.
- `outDone` out 1: transaction complete; high from DONE until `inStart` is low.
- `outDATA` out 8: last byte sampled from the bus.
- `outBusy` out 1: `outDATA[7]` of the last RS=0 read.
- `outAddr` out 7: `outDATA[6:0]` of the last RS=0 read.
- `outTimeout` out 1: poll ended with BF still 1; cleared on the next accepted request.
- `outNibble` out 4: hex value of `outDATA` interpreted as ASCII.
- `outHexValid` out 1: `outDATA` is one of '0'–'9' or 'A'–'F'.
- `outOwn` out 1: the reader owns the bus, SETUP through EN_LO.
- `LCD_DATA_IN` in 8: pad input from the LCD data bus.
- `LCD_RW`, `LCD_EN`, `LCD_RS` out 1 each: bus controls, valid when `outOwn`=1.

## Operation
- States: IDLE, SETUP, EN_HI, EN_LO, DONE.
- **IDLE, request accepted:** when `inStart`=1, latch `inRS` and `inPoll`. Clear `outTimeout` and the poll counter. Go to SETUP.
- **SETUP:** `LCD_RW`=1, `LCD_RS`=latched RS, `LCD_EN`=0, `outOwn`=1. After `T_SETUP` cycles go to EN_HI.
- **EN_HI:** `LCD_EN`=1. On the last cycle, register `LCD_DATA_IN` into `outDATA`. If RS=0, also update `outBusy`/`outAddr`. Then go to EN_LO.
- **EN_LO:** `LCD_EN`=0, RW/RS held. On the last cycle:
  - Poll continues if poll is latched, RS=0, BF=1 and poll count < `POLL_MAX`. Increment the poll count and go to SETUP.
  - Poll exhausted (poll latched, BF=1, count = `POLL_MAX`): set `outTimeout`, go to DONE.
  - Otherwise go to DONE.
- **DONE:** `outOwn`=0, `LCD_RW`=0, `outDone`=1. Go to IDLE when `inStart`=0. A held-high `inStart` never retriggers.
- `inPoll` is ignored when `inRS`=1: exactly one read.
- Timer: one 5-bit down-counter, reloaded on every state entry. Poll counter: 10 bits, saturating.
- `outNibble`/`outHexValid` are combinational from `outDATA`. For a non-hex byte, `outNibble`=0.

## Timing
- Reset values: state IDLE; `LCD_EN`=0, `LCD_RW`=0, `LCD_RS`=0; `outOwn`=0, `outDone`=0; `outDATA`=0, `outBusy`=0, `outAddr`=0, `outTimeout`=0.
- Single read, `inStart` rising to `outDone` rising: 1 + `T_SETUP` + `T_EN_HI` + `T_EN_LO` = 33 cycles.
- Poll latency: 1 + N×32 cycles, where N is the number of reads (N ≤ `POLL_MAX`+1).
- Data is sampled 15 cycles (300 ns) after EN rises, which exceeds HD44780 tDDR = 160 ns.
- `outDATA` is stable from the sample edge until the next sample.
- Reset mid-transaction takes effect immediately and asynchronously: EN drops, `outOwn` drops, any partial poll is discarded.
- `inStart` must not be asserted while LCDController is active; the top level guarantees mutual exclusion.

## Structure
- Shared package `lcd_pkg`:
  - state enum;
  - RS encodings `LCD_RS_INSTR`=0 and `LCD_RS_DATA`=1;
  - default timing constants;
  - BF bit index 7.
- Sub-module `LCDdecoder`: combinational ASCII→nibble inverse of LCDencoder, instantiated once on `outDATA`.

## Test plan
- BF read, bus driving 8'h45, `inRS`=0, `inPoll`=0 → `outDone` at cycle 33, `outBusy`=0, `outAddr`=7'h45, EN high for exactly 16 cycles.
- Data read, bus 8'h41 ('A'), `inRS`=1 → `outDATA`=8'h41, `outNibble`=4'hA, `outHexValid`=1, `outBusy`/`outAddr` unchanged. Bus 8'h3A → `outHexValid`=0.
- Poll, bus 8'h80 for 3 reads then 8'h05 → 4 EN pulses, `outDone` at cycle 129, `outBusy`=0, `outTimeout`=0.
- Poll with `POLL_MAX`=3, bus stuck at 8'h80 → 4 reads, `outTimeout`=1, `outDone`=1. The next request clears `outTimeout`.
- `inStart` held high for 200 cycles → exactly one read. `outDone` stays high until `inStart` falls; IDLE the cycle after.
- `rst` pulsed during EN_HI → `LCD_EN`=0 and `outOwn`=0 with no clock edge, `outDATA`=0. A fresh request afterwards completes normally in 33 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read path: FSM states,
// RS encodings, default bus timing and the busy-flag bit position.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_EN_LO = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_e;

    localparam logic LCD_RS_INSTR = 1'b0;
    localparam logic LCD_RS_DATA  = 1'b1;

    // Default cycle counts at 50 MHz
    localparam int DEF_T_SETUP  = 2;
    localparam int DEF_T_EN_HI  = 16;
    localparam int DEF_T_EN_LO  = 14;
    localparam int DEF_POLL_MAX = 1023;

    localparam int LCD_BF_BIT = 7;

endpackage

// File: rtl/lcd_reader_if.sv
// Host-side request/result bundle of the LCD reader.
interface lcd_reader_if;
    import lcd_pkg::*;

    logic       inStart;
    logic       inRS;
    logic       inPoll;
    logic       outDone;
    logic [7:0] outDATA;
    logic       outBusy;
    logic [6:0] outAddr;
    logic       outTimeout;
    logic [3:0] outNibble;
    logic       outHexValid;

    // Requester side (command sequencer or testbench)
    modport master (
        output inStart, inRS, inPoll,
        input  outDone, outDATA, outBusy, outAddr, outTimeout,
        input  outNibble, outHexValid
    );

    // Reader side
    modport slave (
        input  inStart, inRS, inPoll,
        output outDone, outDATA, outBusy, outAddr, outTimeout,
        output outNibble, outHexValid
    );
endinterface

// File: rtl/LCDdecoder.sv
// ASCII to hex-nibble decoder: inverse of the write-side encoder.
// Accepts '0'-'9' and upper-case 'A'-'F'; anything else gives 0 / invalid.
module LCDdecoder (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       valid
);

    // Map the character range onto its nibble value
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = 4'(ascii - 8'h30);
            valid  = 1'b1;
        end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
            nibble = 4'(ascii - 8'h37);
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine: busy-flag/address and data reads on the 8-bit
// bus, with optional repeated busy-flag polling until the panel is ready.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_EN_HI  = DEF_T_EN_HI,
    parameter int T_EN_LO  = DEF_T_EN_LO,
    parameter int POLL_MAX = DEF_POLL_MAX
) (
    input  logic         clk,
    input  logic         rst,
    lcd_reader_if.slave  host,
    input  logic [7:0]   LCD_DATA_IN,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic         LCD_RS,
    output logic         outOwn
);

    lcd_state_e state_reg, state_next;
    logic [4:0] timer_reg, timer_load;
    logic       rs_reg, poll_reg, timeout_reg, busy_reg;
    logic [9:0] poll_cnt_reg;
    logic [7:0] data_reg;
    logic [6:0] addr_reg;
    logic       timer_done, bf_poll, poll_continue, poll_exhausted;
    logic [3:0] nibble;
    logic       hex_valid;

    assign timer_done = (timer_reg == 5'd0);

    // Poll decisions rely on the BF captured by the read that just finished
    assign bf_poll        = poll_reg && (rs_reg == LCD_RS_INSTR) && busy_reg;
    assign poll_continue  = bf_poll && (poll_cnt_reg < 10'(POLL_MAX));
    assign poll_exhausted = bf_poll && (poll_cnt_reg == 10'(POLL_MAX));

    // Next state, reload value for the shared timer and bus controls
    always_comb begin
        state_next = state_reg;
        timer_load = 5'd0;
        unique case (state_reg)
            ST_IDLE:  if (host.inStart) state_next = ST_SETUP;
            ST_SETUP: if (timer_done) state_next = ST_EN_HI;
            ST_EN_HI: if (timer_done) state_next = ST_EN_LO;
            ST_EN_LO: if (timer_done) state_next = poll_continue ? ST_SETUP : ST_DONE;
            ST_DONE:  if (!host.inStart) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        unique case (state_next)
            ST_SETUP: timer_load = 5'(T_SETUP - 1);
            ST_EN_HI: timer_load = 5'(T_EN_HI - 1);
            ST_EN_LO: timer_load = 5'(T_EN_LO - 1);
            default:  timer_load = 5'd0;
        endcase

        outOwn       = (state_reg == ST_SETUP) || (state_reg == ST_EN_HI) ||
                       (state_reg == ST_EN_LO);
        LCD_RW       = outOwn;
        LCD_RS       = outOwn && (rs_reg == LCD_RS_DATA);
        LCD_EN       = (state_reg == ST_EN_HI);
        host.outDone = (state_reg == ST_DONE);
    end

    // State register and down-counter, reloaded on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            timer_reg <= 5'd0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                timer_reg <= timer_load;
            else if (!timer_done)
                timer_reg <= timer_reg - 5'd1;
        end
    end

    // Request latching, bus sampling and poll bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_reg       <= LCD_RS_INSTR;
            poll_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            poll_cnt_reg <= 10'd0;
            data_reg     <= 8'h00;
            busy_reg     <= 1'b0;
            addr_reg     <= 7'h00;
        end else begin
            if (state_reg == ST_IDLE && host.inStart) begin
                rs_reg       <= host.inRS;
                poll_reg     <= host.inPoll;
                timeout_reg  <= 1'b0;
                poll_cnt_reg <= 10'd0;
            end
            if (state_reg == ST_EN_HI && timer_done) begin
                data_reg <= LCD_DATA_IN;
                if (rs_reg == LCD_RS_INSTR) begin
                    busy_reg <= LCD_DATA_IN[LCD_BF_BIT];
                    addr_reg <= LCD_DATA_IN[6:0];
                end
            end
            if (state_reg == ST_EN_LO && timer_done) begin
                if (poll_continue)
                    poll_cnt_reg <= poll_cnt_reg + 10'd1;
                else if (poll_exhausted)
                    timeout_reg <= 1'b1;
            end
        end
    end

    LCDdecoder u_decoder (
        .ascii  (data_reg),
        .nibble (nibble),
        .valid  (hex_valid)
    );

    assign host.outDATA     = data_reg;
    assign host.outBusy     = busy_reg;
    assign host.outAddr     = addr_reg;
    assign host.outTimeout  = timeout_reg;
    assign host.outNibble   = nibble;
    assign host.outHexValid = hex_valid;

endmodule
